// File: rtl/ec_field_pkg.sv
// Shared definitions for the prime-field point normaliser.
//   P_DEFAULT   : 2^255 - 19, the default field modulus
//   R2_DEFAULT  : R^2 mod P_DEFAULT with R = 2^255 (Montgomery entry constant)
//   E_DEFAULT   : P_DEFAULT - 2, the Fermat inversion exponent
//   state_t     : control states of proj_to_affine
//   popcount_exp: set-bit count of an exponent, gives the number of multiplies
//   ref_modmul / ref_modpow : plain modular arithmetic on small moduli (< 2^32)
package ec_field_pkg;

    // 1 << 255 wraps to 0 in 255 bits, so the subtraction yields 2^255 - 19.
    localparam logic [254:0] P_DEFAULT  = (255'd1 << 255) - 255'd19;
    localparam logic [254:0] R2_DEFAULT = 255'd361;
    localparam logic [254:0] E_DEFAULT  = P_DEFAULT - 255'd2;

    typedef enum logic [2:0] {
        IDLE,
        TO_MONT,
        SQR,
        MUL,
        DIV_X,
        DIV_Y,
        FIX,
        OUT
    } state_t;

    function automatic int popcount_exp(input logic [255:0] e);
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            n += int'(e[i]);
        end
        return n;
    endfunction

    function automatic logic [63:0] ref_modmul(input logic [63:0] a,
                                               input logic [63:0] b,
                                               input logic [63:0] m);
        return (a * b) % m;
    endfunction

    function automatic logic [63:0] ref_modpow(input logic [63:0] b,
                                               input logic [63:0] e,
                                               input logic [63:0] m);
        logic [63:0] r;
        logic [63:0] base;
        r    = 64'd1 % m;
        base = b % m;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = ref_modmul(r, base, m);
            base = ref_modmul(base, base, m);
        end
        return r;
    endfunction

endpackage

// File: rtl/montgomery_mul.sv
// Bit-serial radix-2 Montgomery multiplier: o_result = a * b * 2^-WIDTH mod MODULUS.
//   i_clk, i_rst    : clock, synchronous active-high reset (aborts any operation)
//   i_start         : one-cycle request, operands sampled on that edge
//   i_a, i_b        : operands, each < MODULUS
//   o_result        : product, < MODULUS, held until the next completion
//   o_finished      : one-cycle pulse, WIDTH+2 cycles after the start cycle
module montgomery_mul
    import ec_field_pkg::*;
#(
    parameter int               WIDTH   = 255,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(P_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH+1:0] acc;      // stays below 2*MODULUS between iterations
    logic [WIDTH+1:0] sum_ab;
    logic [WIDTH+1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             last;

    assign last = (cnt == CNT_W'(WIDTH));

    // One reduction step: add a_i*b, add MODULUS if odd so the halving is exact.
    always_comb begin
        sum_ab = acc + (a_sh[0] ? {2'b00, b_q} : '0);
        sum_q  = sum_ab[0] ? (sum_ab + {2'b00, MODULUS}) : sum_ab;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy       <= 1'b0;
            cnt        <= '0;
            o_finished <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            if (i_start) begin
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                if (last) begin
                    busy       <= 1'b0;
                    o_finished <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            a_sh <= i_a;
            b_q  <= i_b;
            acc  <= '0;
        end else if (busy) begin
            if (last) begin
                // Final conditional subtraction brings [0, 2M) into [0, M).
                o_result <= (acc >= {2'b00, MODULUS}) ? WIDTH'(acc - {2'b00, MODULUS})
                                                      : acc[WIDTH-1:0];
            end else begin
                acc  <= sum_q >> 1;
                a_sh <= a_sh >> 1;
            end
        end
    end

endmodule

// File: rtl/proj_to_affine.sv
// Projective-to-affine normaliser: (x, y, z) -> (x/z, y/z) mod MODULUS.
// z^-1 is formed as z^(MODULUS-2) by left-to-right square-and-multiply on a single
// Montgomery multiplier; the x and y divisions reuse the same multiplier.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_valid, o_ready        : input handshake (o_ready only while idle)
//   i_x, i_y, i_z           : projective coordinates, each < MODULUS
//   o_valid, i_ready        : output handshake, result held until taken
//   o_x, o_y                : affine result in [0, MODULUS)
//   o_z_zero                : input z was 0 (point at infinity)
// NEG_ODD=1 replaces each odd nonzero coordinate v with MODULUS - v.
module proj_to_affine
    import ec_field_pkg::*;
#(
    parameter int               WIDTH   = 255,
    parameter logic [WIDTH-1:0] MODULUS = WIDTH'(P_DEFAULT),
    parameter logic [WIDTH-1:0] R2_MOD  = WIDTH'(R2_DEFAULT),
    parameter bit               NEG_ODD = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_z,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_z_zero
);

    localparam logic [WIDTH-1:0] EXP = MODULUS - WIDTH'(2);
    localparam int               K_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_d;
    logic [K_W-1:0]   k;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] zm_q;
    logic [WIDTH-1:0] acc_q;
    logic             mm_start;
    logic             mm_done;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_res;
    logic             exp_bit;
    logic             k_last;

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v);
        if (NEG_ODD && v[0]) return MODULUS - v;
        return v;
    endfunction

    assign exp_bit = EXP[k];
    assign k_last  = (k == '0);
    assign o_ready = (state == IDLE);
    assign o_valid = (state == OUT);

    montgomery_mul #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_mm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mm_start),
        .i_a        (mm_a),
        .i_b        (mm_b),
        .o_result   (mm_res),
        .o_finished (mm_done)
    );

    // Next state and multiplier launch. Each new multiply starts in the cycle the
    // previous one finishes, so the freshly finished product (mm_res) stands in
    // for the accumulator that is only written on that same edge.
    always_comb begin
        state_d  = state;
        mm_start = 1'b0;
        mm_a     = mm_res;
        mm_b     = mm_res;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_z == '0) begin
                        state_d = OUT;
                    end else begin
                        state_d  = TO_MONT;
                        mm_start = 1'b1;
                        mm_a     = i_z;
                        mm_b     = R2_MOD;
                    end
                end
            end
            TO_MONT: begin
                // Exponent MSB is 1, so the accumulator starts at zM and squares.
                if (mm_done) begin
                    state_d  = SQR;
                    mm_start = 1'b1;
                end
            end
            SQR: begin
                if (mm_done) begin
                    mm_start = 1'b1;
                    if (exp_bit) begin
                        state_d = MUL;
                        mm_b    = zm_q;
                    end else if (k_last) begin
                        state_d = DIV_X;
                        mm_a    = x_q;
                    end
                end
            end
            MUL: begin
                if (mm_done) begin
                    mm_start = 1'b1;
                    if (k_last) begin
                        state_d = DIV_X;
                        mm_a    = x_q;
                    end else begin
                        state_d = SQR;
                    end
                end
            end
            DIV_X: begin
                if (mm_done) begin
                    state_d  = DIV_Y;
                    mm_start = 1'b1;
                    mm_a     = y_q;
                    mm_b     = acc_q;
                end
            end
            DIV_Y: begin
                if (mm_done) state_d = FIX;
            end
            FIX: begin
                state_d = OUT;
            end
            OUT: begin
                if (i_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            k        <= '0;
            o_x      <= '0;
            o_y      <= '0;
            o_z_zero <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        k <= K_W'(WIDTH - 2);
                        if (i_z == '0) begin
                            o_x      <= '0;
                            o_y      <= '0;
                            o_z_zero <= 1'b1;
                        end
                    end
                end
                SQR: begin
                    if (mm_done && !exp_bit && !k_last) k <= k - K_W'(1);
                end
                MUL: begin
                    if (mm_done && !k_last) k <= k - K_W'(1);
                end
                FIX: begin
                    o_x      <= sign_fix(x_q);
                    o_y      <= sign_fix(y_q);
                    o_z_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == IDLE && i_valid) begin
            x_q <= i_x;
            y_q <= i_y;
        end
        if (mm_done) begin
            case (state)
                TO_MONT:  zm_q  <= mm_res;
                SQR, MUL: acc_q <= mm_res;
                DIV_X:    x_q   <= mm_res;
                DIV_Y:    y_q   <= mm_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proj_to_affine.sv
// Scoreboard bench for proj_to_affine on a 16-bit field (p = 65521) with two
// instances sharing stimulus: NEG_ODD=0 (dut0) and NEG_ODD=1 (dut1).
module tb_proj_to_affine;
    import ec_field_pkg::*;

    localparam int               W    = 16;
    localparam logic [W-1:0]     P    = 16'd65521;
    localparam logic [W-1:0]     R2   = 16'd225;     // (2^16 mod p)^2 = 15^2
    localparam int               T_MM = W + 2;
    localparam int               N_MM = 1 + (W - 1) + (popcount_exp(256'(P - 16'd2)) - 1) + 2;
    localparam int               LAT  = N_MM * T_MM + 2;

    logic         clk;
    logic         rst;
    logic         valid;
    logic [W-1:0] x, y, z;
    logic         rdy_in;
    logic         ready0, valid0, zz0;
    logic [W-1:0] x0, y0;
    logic         ready1, valid1, zz1;
    logic [W-1:0] x1, y1;

    typedef struct {
        logic [W-1:0] x0, y0, x1, y1;
        logic         zz;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    proj_to_affine #(.WIDTH(W), .MODULUS(P), .R2_MOD(R2), .NEG_ODD(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready0),
        .i_x(x), .i_y(y), .i_z(z), .o_valid(valid0), .i_ready(rdy_in),
        .o_x(x0), .o_y(y0), .o_z_zero(zz0)
    );

    proj_to_affine #(.WIDTH(W), .MODULUS(P), .R2_MOD(R2), .NEG_ODD(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready1),
        .i_x(x), .i_y(y), .i_z(z), .o_valid(valid1), .i_ready(rdy_in),
        .o_x(x1), .o_y(y1), .o_z_zero(zz1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic zz, input int lat);
        exp_t e;
        e.x0 = a; e.y0 = b; e.x1 = c; e.y1 = d;
        e.zz = zz; e.lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    function automatic exp_t model(input logic [W-1:0] mx, input logic [W-1:0] my,
                                   input logic [W-1:0] mz);
        logic [63:0] inv, ax, ay, p64;
        if (mz == '0) return mk('0, '0, '0, '0, 1'b1, 1);
        p64 = 64'(P);
        inv = ref_modpow(64'(mz), p64 - 64'd2, p64);
        ax  = (64'(mx) * inv) % p64;
        ay  = (64'(my) * inv) % p64;
        return mk(W'(ax), W'(ay),
                  ax[0] ? W'(p64 - ax) : W'(ax),
                  ay[0] ? W'(p64 - ay) : W'(ay), 1'b0, LAT);
    endfunction

    // Drive one point and wait (bounded) for it to be accepted.
    task automatic send(input logic [W-1:0] sx, input logic [W-1:0] sy,
                        input logic [W-1:0] sz, input exp_t e);
        int n;
        n = 0;
        valid = 1'b1; x = sx; y = sy; z = sz;
        @(negedge clk);
        while (!ready0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready0) begin
            tests++; fails++;
            $display("FAIL accept_timeout: got ready 0, expected 1 within 2000 cycles");
        end else begin
            e.acc_cyc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Monitor: latency at the rising edge of o_valid, hold stability while
    // stalled, full compare on each handshake.
    logic         pv = 1'b0;
    logic [W-1:0] hx0, hy0, hx1, hy1;
    logic         hz0, hz1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (valid0 && !pv) begin
                hx0 = x0; hy0 = y0; hz0 = zz0; hx1 = x1; hy1 = y1; hz1 = zz1;
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_valid: got o_valid 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("latency", cyc - q[0].acc_cyc, q[0].lat);
                end
            end
            if (valid0 && pv) begin
                chk("hold_x0", x0, hx0);  chk("hold_y0", y0, hy0);  chk("hold_z0", zz0, hz0);
                chk("hold_x1", x1, hx1);  chk("hold_y1", y1, hy1);  chk("hold_z1", zz1, hz1);
                chk("hold_ready", ready0, 0);
            end
            if (valid0 && rdy_in && q.size() > 0) begin
                e = q.pop_front();
                chk("x_neg0", x0, e.x0);  chk("y_neg0", y0, e.y0);  chk("zz_neg0", zz0, e.zz);
                chk("x_neg1", x1, e.x1);  chk("y_neg1", y1, e.y1);  chk("zz_neg1", zz1, e.zz);
                chk("valid_neg1", valid1, 1);
            end
            pv = valid0 && !rdy_in;
        end
    end

    initial begin
        logic [W-1:0] rx, ry, rz;
        int n;
        rst = 1'b1; valid = 1'b0; x = '0; y = '0; z = '0; rdy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready0", ready0, 1); chk("rst_valid0", valid0, 0);
        chk("rst_ready1", ready1, 1); chk("rst_valid1", valid1, 0);
        chk("rst_x0", x0, 0); chk("rst_y0", y0, 0); chk("rst_zz0", zz0, 0);
        chk("rst_x1", x1, 0); chk("rst_y1", y1, 0); chk("rst_zz1", zz1, 0);
        @(posedge clk); #1;

        // Directed points with hand-computed results (p = 65521).
        send(16'd5, 16'd7, 16'd1, mk(16'd5, 16'd7, 16'd65516, 16'd65514, 1'b0, LAT));
        send(16'd4, 16'd6, 16'd2, mk(16'd2, 16'd3, 16'd2, 16'd65518, 1'b0, LAT));
        send(16'd9, 16'd9, 16'd0, mk(16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1));
        send(16'd0, 16'd10, 16'd5, mk(16'd0, 16'd2, 16'd0, 16'd2, 1'b0, LAT));
        // Busy: a stray request must be ignored, not queued.
        valid = 1'b1; x = 16'd77; y = 16'd88; z = 16'd99;
        repeat (3) @(posedge clk);
        #1 valid = 1'b0;
        send(16'd65520, 16'd65519, 16'd65520, mk(16'd1, 16'd2, 16'd65520, 16'd2, 1'b0, LAT));

        // Backpressure: hold i_ready low for 20 cycles after o_valid.
        n = 0;
        while (!ready0 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rdy_in = 1'b0;
        send(16'd12, 16'd10, 16'd2, mk(16'd6, 16'd5, 16'd6, 16'd65516, 1'b0, LAT));
        n = 0;
        while (!valid0 && n < 2000) begin @(negedge clk); n++; end
        chk("stall_valid_seen", valid0, 1);
        repeat (20) begin
            @(negedge clk);
            chk("stall_ready0", ready0, 0);
            chk("stall_valid0", valid0, 1);
        end
        @(posedge clk); #1 rdy_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_ready0", ready0, 1);
        chk("release_valid0", valid0, 0);
        @(posedge clk); #1;

        // Reset in the middle of the squaring phase discards the point.
        send(16'd7, 16'd7, 16'd3, mk(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, LAT));
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("midrst_valid0", valid0, 0); chk("midrst_ready0", ready0, 1);
        chk("midrst_valid1", valid1, 0);
        @(posedge clk); #1;
        send(16'd3, 16'd1, 16'd1, mk(16'd3, 16'd1, 16'd65518, 16'd65520, 1'b0, LAT));

        // Reset and a request in the same cycle: reset wins.
        n = 0;
        while (!ready0 && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        rst = 1'b1; valid = 1'b1; x = 16'd1; y = 16'd1; z = 16'd1;
        @(posedge clk); #1;
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("rstv_ready0", ready0, 1); chk("rstv_valid0", valid0, 0);
        @(posedge clk); #1;

        // Back-to-back random points against the reference model.
        for (int i = 0; i < 50; i++) begin
            rx = W'($urandom_range(0, 65520));
            ry = W'($urandom_range(0, 65520));
            rz = W'($urandom_range(0, 65520));
            send(rx, ry, rz, model(rx, ry, rz));
        end

        n = 0;
        while (q.size() > 0 && n < 5000) begin @(negedge clk); n++; end
        if (q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
